e_md_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit (HI/LO register pair) in the E stage of the 5-stage pipeline.

---
 rtl/e_md_unit.sv | 151 +++++++++++++++
 tb/tb_e_md_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/e_md_unit.sv
// E-stage multi-cycle multiply/divide unit with HI/LO register pair.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MACC_EN.
module e_md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } md_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    md_op_t           op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_d, lo_d;

    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc_new;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   div_den, quot, rem;

    // Datapath works from latched operands only.
    always_comb begin
        is_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        a_ext     = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext     = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod      = a_ext * b_ext;

        div_zero  = (b_q == '0);
        div_ovf   = (op_q == OP_DIV) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        // Divisor forced to 1 for /0 and MIN/-1: the latter then yields lo=a, hi=0 directly.
        div_den   = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
        if (op_q == OP_DIV) begin
            quot = $signed(a_q) / $signed(div_den);
            rem  = $signed(a_q) % $signed(div_den);
        end else begin
            quot = a_q / div_den;
            rem  = a_q % div_den;
        end

        acc_new = {hi, lo};
        case (op_q)
            OP_MULT, OP_MULTU: acc_new = prod;
            OP_DIV, OP_DIVU:   if (!div_zero) acc_new = {rem, quot};
`ifdef MDU_MACC_EN
            OP_MADD, OP_MADDU: acc_new = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: acc_new = {hi, lo} - prod;
`endif
            default:           acc_new = {hi, lo};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU
`ifdef MDU_MACC_EN
                        , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
                        : begin
                            state_d = ST_RUN;
                            cnt_d   = CW'(MUL_LAT);
                            op_d    = md_op_t'(op);
                            a_d     = a;
                            b_d     = b;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_RUN;
                            cnt_d   = CW'(DIV_LAT);
                            op_d    = md_op_t'(op);
                            a_d     = a;
                            b_d     = b;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = ST_IDLE;
                    {hi_d, lo_d} = acc_new;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_e_md_unit.sv
// Randomized self-checking bench for e_md_unit against an arithmetic HI/LO model.
// Honours MDU_MACC_EN the same way as the design.
module tb_e_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] hl_exp  = '0;

    e_md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] o);
        case (o)
            4'd0, 4'd1: return 5;
            4'd2, 4'd3: return 10;
`ifdef MDU_MACC_EN
            4'd6, 4'd7, 4'd8, 4'd9: return 5;
`endif
            default: return 0;
        endcase
    endfunction

    // Reference: {hi,lo} as one 64-bit value updated by plain integer arithmetic.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx, sy, q, r;
        logic [63:0] sp, up;
        sx = x;
        sy = y;
        sp = longint'(sx) * longint'(sy);
        up = {32'b0, x} * {32'b0, y};
        case (o)
            4'd0: hl_exp = sp;
            4'd1: hl_exp = up;
            4'd2: if (y != 0) begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) hl_exp = {32'h0, x};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    hl_exp = {r, q};
                end
            end
            4'd3: if (y != 0) hl_exp = {x % y, x / y};
            4'd4: hl_exp[63:32] = x;
            4'd5: hl_exp[31:0]  = x;
`ifdef MDU_MACC_EN
            4'd6: hl_exp = hl_exp + sp;
            4'd7: hl_exp = hl_exp + up;
            4'd8: hl_exp = hl_exp - sp;
            4'd9: hl_exp = hl_exp - up;
`endif
            default: ;
        endcase
    endtask

    // Launch one op, optionally disturbing pins while busy, then check latency and HI/LO.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit noise, input int mtlo_at);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        model(o, x, y);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == mtlo_at) begin
                start = 1'b1; op = 4'd5; a = 32'h55;
            end else if (noise) begin
                start = 1'($urandom_range(0, 1));
                op = 4'($urandom);
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("lat op%0d", o), 64'(n), 64'(exp_lat(o)));
        check($sformatf("hi op%0d", o), {32'b0, hi}, {32'b0, hl_exp[63:32]});
        check($sformatf("lo op%0d", o), {32'b0, lo}, {32'b0, hl_exp[31:0]});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #12;
        check("reset busy", {63'b0, busy}, 64'h0);
        check("reset hi", {32'b0, hi}, 64'h0);
        check("reset lo", {32'b0, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        run_op(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
        check("mult hi const", {32'b0, hi}, 64'hFFFF_FFFF);
        check("mult lo const", {32'b0, lo}, 64'hFFFF_FFFA);
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
        check("multu hi const", {32'b0, hi}, 64'h2);
        run_op(4'd2, -32'sd7, 32'd2, 1'b0, -1);
        check("div lo const", {32'b0, lo}, 64'hFFFF_FFFD);
        check("div hi const", {32'b0, hi}, 64'hFFFF_FFFF);
        run_op(4'd3, 32'd7, 32'd0, 1'b0, -1);
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        check("div ovf lo const", {32'b0, lo}, 64'h8000_0000);
        run_op(4'd0, 32'd3, 32'd4, 1'b0, 2);
        check("mtlo dropped lo", {32'b0, lo}, 64'd12);
        run_op(4'd0, 32'd5, 32'd6, 1'b0, -1);
        run_op(4'd4, 32'h1234, 32'd0, 1'b0, -1);
        check("mthi hi const", {32'b0, hi}, 64'h1234);
        check("mthi lo kept", {32'b0, lo}, 64'd30);

        run_op(4'd4, 32'h0, 32'd0, 1'b0, -1);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, -1);
        run_op(4'd7, 32'd1, 32'd1, 1'b0, -1);
`ifdef MDU_MACC_EN
        check("maddu hi const", {32'b0, hi}, 64'h1);
        check("maddu lo const", {32'b0, lo}, 64'h0);
`else
        check("maddu off hi", {32'b0, hi}, 64'h0);
        check("maddu off lo", {32'b0, lo}, 64'hFFFF_FFFF);
`endif

        // Async reset mid-DIV with the counter at 4.
        run_op(4'd0, 32'd9, 32'd9, 1'b0, -1);
        @(negedge clk);
        start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("busy before abort", {63'b0, busy}, 64'h1);
        #2 reset = 1'b0;
        #1;
        check("abort busy", {63'b0, busy}, 64'h0);
        check("abort hi", {32'b0, hi}, 64'h0);
        check("abort lo", {32'b0, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        hl_exp = '0;
        run_op(4'd1, 32'd2, 32'd21, 1'b0, -1);

        for (int i = 0; i < 300; i++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
